// File: rtl/ddr3_arbiter_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ddr3_arbiter_if : single-word DDR3 command/read-return port bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
interface ddr3_arbiter_if;
  logic [26:2] addr;
  logic [31:0] write_data;
  logic [3:0]  byte_enable;
  logic        write_req;
  logic        read_req;
  logic        ready;
  logic [31:0] read_data;
  logic        read_data_valid;

  // The requester side of a link; the arbiter is master toward the memory.
  modport master (
    output addr, write_data, byte_enable, write_req, read_req,
    input  ready, read_data, read_data_valid
  );

  modport slave (
    input  addr, write_data, byte_enable, write_req, read_req,
    output ready, read_data, read_data_valid
  );
endinterface
`default_nettype wire

// File: rtl/ddr3_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ddr3_arbiter : two-port round-robin DDR3 command arbiter with read-tag FIFO
// Revision: 1.0
// ----------------------------------------------------------------------------
module ddr3_arbiter #(
  parameter int DEPTH_BITS = 4
) (
  input  wire logic      clk,
  input  wire logic      reset,
  ddr3_arbiter_if.slave  p0,
  ddr3_arbiter_if.slave  p1,
  ddr3_arbiter_if.master mem,
  output logic           tag_error
);

  localparam int DEPTH = 1 << DEPTH_BITS;

  logic                  priority_q, priority_d;
  logic                  tag_error_q, tag_error_d;
  logic [DEPTH_BITS:0]   count_q, count_d;
  logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic                  tags_q [DEPTH];

  logic fifo_empty, fifo_full, rd_block, pop;
  logic req0, req1, elig0, elig1;
  logic gnt_valid, gnt, sel;
  logic ready0, ready1, accept, push, head;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (DEPTH_BITS+1)'(DEPTH));
  // A return in the same cycle frees a slot, so a full FIFO only blocks
  // reads when nothing is popping.
  assign rd_block   = fifo_full && !mem.read_data_valid;
  assign pop        = mem.read_data_valid && !fifo_empty;
  assign head       = tags_q[rd_ptr_q];

  assign req0  = p0.read_req | p0.write_req;
  assign req1  = p1.read_req | p1.write_req;
  assign elig0 = req0 && !(p0.read_req && rd_block);
  assign elig1 = req1 && !(p1.read_req && rd_block);

  always_comb begin
    gnt_valid = 1'b0;
    gnt       = 1'b0;
    if (elig0 && elig1) begin
      gnt_valid = 1'b1;
      gnt       = priority_q;
    end else if (elig0) begin
      gnt_valid = 1'b1;
      gnt       = 1'b0;
    end else if (elig1) begin
      gnt_valid = 1'b1;
      gnt       = 1'b1;
    end
  end

  assign sel    = gnt_valid ? gnt : 1'b0;
  assign ready0 = !reset && mem.ready && gnt_valid && (gnt == 1'b0);
  assign ready1 = !reset && mem.ready && gnt_valid && (gnt == 1'b1);
  assign accept = (req0 && ready0) || (req1 && ready1);
  assign push   = accept && (sel ? p1.read_req : p0.read_req);

  assign p0.ready = ready0;
  assign p1.ready = ready1;

  assign mem.addr        = sel ? p1.addr        : p0.addr;
  assign mem.write_data  = sel ? p1.write_data  : p0.write_data;
  assign mem.byte_enable = sel ? p1.byte_enable : p0.byte_enable;
  assign mem.write_req   = !reset && gnt_valid && (sel ? p1.write_req : p0.write_req);
  assign mem.read_req    = !reset && gnt_valid && (sel ? p1.read_req  : p0.read_req);

  assign p0.read_data       = mem.read_data;
  assign p1.read_data       = mem.read_data;
  assign p0.read_data_valid = !reset && pop && (head == 1'b0);
  assign p1.read_data_valid = !reset && pop && (head == 1'b1);

  assign tag_error = tag_error_q;

  always_comb begin
    priority_d  = priority_q;
    tag_error_d = tag_error_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (accept) priority_d = ~sel;
    if (mem.read_data_valid && fifo_empty) tag_error_d = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      priority_q  <= 1'b0;
      tag_error_q <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      priority_q  <= priority_d;
      tag_error_q <= tag_error_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  // Tag storage needs no reset: entries are only read once pushed.
  always_ff @(posedge clk) begin
    if (push && !reset) tags_q[wr_ptr_q] <= sel;
  end

endmodule
`default_nettype wire
